// File: rtl/reservation_station_if.sv
// Bundled dispatch, CDB snoop, issue and status signals of the reservation station.
// The RS itself connects through the slave modport; the surrounding pipeline uses master.
interface reservation_station_if #(
  parameter int ENT_NUM   = 2,
  parameter int ENT_SEL   = 1,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 16
);
  logic                 i_disp_vld;
  logic [PAYLOAD_W-1:0] i_disp_payload;
  logic                 i_disp_src1_rdy;
  logic [TAG_W-1:0]     i_disp_src1_tag;
  logic [DATA_W-1:0]    i_disp_src1_data;
  logic                 i_disp_src2_rdy;
  logic [TAG_W-1:0]     i_disp_src2_tag;
  logic [DATA_W-1:0]    i_disp_src2_data;
  logic                 i_cdb0_vld;
  logic [TAG_W-1:0]     i_cdb0_tag;
  logic [DATA_W-1:0]    i_cdb0_data;
  logic                 i_cdb1_vld;
  logic [TAG_W-1:0]     i_cdb1_tag;
  logic [DATA_W-1:0]    i_cdb1_data;
  logic                 o_full;
  logic [ENT_SEL:0]     o_free_cnt;
  logic [ENT_NUM-1:0]   o_ready_vec;
  logic                 i_issue_vld;
  logic [ENT_SEL-1:0]   i_issue_sel;
  logic                 o_issue_vld;
  logic [PAYLOAD_W-1:0] o_issue_payload;
  logic [DATA_W-1:0]    o_issue_src1;
  logic [DATA_W-1:0]    o_issue_src2;
  logic                 i_flush;

  modport master (
    output i_disp_vld, i_disp_payload,
    output i_disp_src1_rdy, i_disp_src1_tag, i_disp_src1_data,
    output i_disp_src2_rdy, i_disp_src2_tag, i_disp_src2_data,
    output i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
    output i_cdb1_vld, i_cdb1_tag, i_cdb1_data,
    output i_issue_vld, i_issue_sel, i_flush,
    input  o_full, o_free_cnt, o_ready_vec,
    input  o_issue_vld, o_issue_payload, o_issue_src1, o_issue_src2
  );

  modport slave (
    input  i_disp_vld, i_disp_payload,
    input  i_disp_src1_rdy, i_disp_src1_tag, i_disp_src1_data,
    input  i_disp_src2_rdy, i_disp_src2_tag, i_disp_src2_data,
    input  i_cdb0_vld, i_cdb0_tag, i_cdb0_data,
    input  i_cdb1_vld, i_cdb1_tag, i_cdb1_data,
    input  i_issue_vld, i_issue_sel, i_flush,
    output o_full, o_free_cnt, o_ready_vec,
    output o_issue_vld, o_issue_payload, o_issue_src1, o_issue_src2
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched insts until both operands arrive via CDB wakeup.
// Optional feature macro: RS_FLUSH_EN (i_flush clears all entries; ignored when undefined).
module reservation_station #(
  parameter int ENT_NUM   = 2,
  parameter int ENT_SEL   = 1,
  parameter int TAG_W     = 6,
  parameter int DATA_W    = 32,
  parameter int PAYLOAD_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  reservation_station_if.slave rs
);

  logic [ENT_NUM-1:0]   valid_q, valid_d;
  logic [ENT_NUM-1:0]   src1Rdy_q, src1Rdy_d, src2Rdy_q, src2Rdy_d;
  logic [TAG_W-1:0]     src1Tag_q [ENT_NUM];
  logic [TAG_W-1:0]     src1Tag_d [ENT_NUM];
  logic [TAG_W-1:0]     src2Tag_q [ENT_NUM];
  logic [TAG_W-1:0]     src2Tag_d [ENT_NUM];
  logic [DATA_W-1:0]    src1Data_q [ENT_NUM];
  logic [DATA_W-1:0]    src1Data_d [ENT_NUM];
  logic [DATA_W-1:0]    src2Data_q [ENT_NUM];
  logic [DATA_W-1:0]    src2Data_d [ENT_NUM];
  logic [PAYLOAD_W-1:0] payload_q [ENT_NUM];
  logic [PAYLOAD_W-1:0] payload_d [ENT_NUM];

  logic [ENT_SEL:0]     freeCnt;
  logic [ENT_SEL-1:0]   freeIdx;
  logic [ENT_NUM-1:0]   readyVec;
  logic                 full;
  logic                 issueVld;
  logic                 dispAccept;
  logic                 flushNow;
  logic                 d1Hit0, d1Hit1, d2Hit0, d2Hit1;

`ifdef RS_FLUSH_EN
  assign flushNow = rs.i_flush;
`else
  assign flushNow = 1'b0;
`endif

  // Descending scan so the last hit left in freeIdx is the lowest free entry.
  always_comb begin
    freeCnt = '0;
    freeIdx = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        freeCnt = freeCnt + (ENT_SEL + 1)'(1);
        freeIdx = ENT_SEL'(i);
      end
    end
  end

  assign full        = &valid_q;
  assign readyVec    = valid_q & src1Rdy_q & src2Rdy_q;
  assign issueVld    = rs.i_issue_vld & readyVec[rs.i_issue_sel] & ~flushNow;
  assign dispAccept  = rs.i_disp_vld & ~full;

  assign rs.o_full          = full;
  assign rs.o_free_cnt      = freeCnt;
  assign rs.o_ready_vec     = readyVec;
  assign rs.o_issue_vld     = issueVld;
  assign rs.o_issue_payload = payload_q[rs.i_issue_sel];
  assign rs.o_issue_src1    = src1Data_q[rs.i_issue_sel];
  assign rs.o_issue_src2    = src2Data_q[rs.i_issue_sel];

  assign d1Hit0 = rs.i_cdb0_vld && (rs.i_cdb0_tag == rs.i_disp_src1_tag);
  assign d1Hit1 = rs.i_cdb1_vld && (rs.i_cdb1_tag == rs.i_disp_src1_tag);
  assign d2Hit0 = rs.i_cdb0_vld && (rs.i_cdb0_tag == rs.i_disp_src2_tag);
  assign d2Hit1 = rs.i_cdb1_vld && (rs.i_cdb1_tag == rs.i_disp_src2_tag);

  always_comb begin
    valid_d    = valid_q;
    src1Rdy_d  = src1Rdy_q;
    src2Rdy_d  = src2Rdy_q;
    src1Tag_d  = src1Tag_q;
    src2Tag_d  = src2Tag_q;
    src1Data_d = src1Data_q;
    src2Data_d = src2Data_q;
    payload_d  = payload_q;

    for (int i = 0; i < ENT_NUM; i++) begin
      if (valid_q[i] && !src1Rdy_q[i]) begin
        if (rs.i_cdb0_vld && rs.i_cdb0_tag == src1Tag_q[i]) begin
          src1Rdy_d[i]  = 1'b1;
          src1Data_d[i] = rs.i_cdb0_data;
        end else if (rs.i_cdb1_vld && rs.i_cdb1_tag == src1Tag_q[i]) begin
          src1Rdy_d[i]  = 1'b1;
          src1Data_d[i] = rs.i_cdb1_data;
        end
      end
      if (valid_q[i] && !src2Rdy_q[i]) begin
        if (rs.i_cdb0_vld && rs.i_cdb0_tag == src2Tag_q[i]) begin
          src2Rdy_d[i]  = 1'b1;
          src2Data_d[i] = rs.i_cdb0_data;
        end else if (rs.i_cdb1_vld && rs.i_cdb1_tag == src2Tag_q[i]) begin
          src2Rdy_d[i]  = 1'b1;
          src2Data_d[i] = rs.i_cdb1_data;
        end
      end
    end

    if (issueVld) valid_d[rs.i_issue_sel] = 1'b0;

    // freeIdx comes from registered state, so a slot freed by issue this cycle is never reused here.
    if (dispAccept) begin
      valid_d[freeIdx]   = 1'b1;
      payload_d[freeIdx] = rs.i_disp_payload;
      src1Tag_d[freeIdx] = rs.i_disp_src1_tag;
      src2Tag_d[freeIdx] = rs.i_disp_src2_tag;
      src1Rdy_d[freeIdx] = rs.i_disp_src1_rdy | d1Hit0 | d1Hit1;
      src2Rdy_d[freeIdx] = rs.i_disp_src2_rdy | d2Hit0 | d2Hit1;
      src1Data_d[freeIdx] = rs.i_disp_src1_rdy ? rs.i_disp_src1_data :
                            d1Hit0 ? rs.i_cdb0_data :
                            d1Hit1 ? rs.i_cdb1_data : rs.i_disp_src1_data;
      src2Data_d[freeIdx] = rs.i_disp_src2_rdy ? rs.i_disp_src2_data :
                            d2Hit0 ? rs.i_cdb0_data :
                            d2Hit1 ? rs.i_cdb1_data : rs.i_disp_src2_data;
    end

    if (flushNow) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q   <= '0;
      src1Rdy_q <= '0;
      src2Rdy_q <= '0;
    end else begin
      valid_q    <= valid_d;
      src1Rdy_q  <= src1Rdy_d;
      src2Rdy_q  <= src2Rdy_d;
      src1Tag_q  <= src1Tag_d;
      src2Tag_q  <= src2Tag_d;
      src1Data_q <= src1Data_d;
      src2Data_q <= src2Data_d;
      payload_q  <= payload_d;
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station (2 entries).
// Expected values are hand-computed per step; RS_FLUSH_EN selects the flush scenario.
module tb_reservation_station;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  reservation_station_if #(.ENT_NUM(2), .ENT_SEL(1), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(16)) rsIf ();

  reservation_station #(.ENT_NUM(2), .ENT_SEL(1), .TAG_W(6), .DATA_W(32), .PAYLOAD_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .rs    (rsIf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts the error and reports it.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearInputs();
    rsIf.i_disp_vld       = 1'b0;
    rsIf.i_disp_payload   = '0;
    rsIf.i_disp_src1_rdy  = 1'b0;
    rsIf.i_disp_src1_tag  = '0;
    rsIf.i_disp_src1_data = '0;
    rsIf.i_disp_src2_rdy  = 1'b0;
    rsIf.i_disp_src2_tag  = '0;
    rsIf.i_disp_src2_data = '0;
    rsIf.i_cdb0_vld       = 1'b0;
    rsIf.i_cdb0_tag       = '0;
    rsIf.i_cdb0_data      = '0;
    rsIf.i_cdb1_vld       = 1'b0;
    rsIf.i_cdb1_tag       = '0;
    rsIf.i_cdb1_data      = '0;
    rsIf.i_issue_vld      = 1'b0;
    rsIf.i_issue_sel      = '0;
    rsIf.i_flush          = 1'b0;
  endtask

  // Advances one clock; inputs are then changed 1ns after the edge, outputs sampled later.
  task automatic tick();
    @(posedge clk);
    #1;
    clearInputs();
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] payload,
                               input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                               input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    rsIf.i_disp_vld       = 1'b1;
    rsIf.i_disp_payload   = payload;
    rsIf.i_disp_src1_rdy  = r1;
    rsIf.i_disp_src1_tag  = t1;
    rsIf.i_disp_src1_data = d1;
    rsIf.i_disp_src2_rdy  = r2;
    rsIf.i_disp_src2_tag  = t2;
    rsIf.i_disp_src2_data = d2;
  endtask

  task automatic grant(input logic sel);
    rsIf.i_issue_vld = 1'b1;
    rsIf.i_issue_sel = sel;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_free_cnt", rsIf.o_free_cnt, 2);
    checkOutput("rst_ready_vec", rsIf.o_ready_vec, 0);
    checkOutput("rst_full", rsIf.o_full, 0);
    checkOutput("rst_issue_vld", rsIf.o_issue_vld, 0);

    // Both sources ready at dispatch
    applyStimulus(16'h1234, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd7);
    #1;
    checkOutput("t2_ready_same_cycle", rsIf.o_ready_vec, 0);
    tick();
    checkOutput("t2_ready_vec", rsIf.o_ready_vec, 2'b01);
    checkOutput("t2_free_cnt", rsIf.o_free_cnt, 1);
    grant(1'b0);
    checkOutput("t2_issue_vld", rsIf.o_issue_vld, 1);
    checkOutput("t2_issue_src1", rsIf.o_issue_src1, 5);
    checkOutput("t2_issue_src2", rsIf.o_issue_src2, 7);
    checkOutput("t2_issue_payload", rsIf.o_issue_payload, 16'h1234);
    tick();
    checkOutput("t2_freed_cnt", rsIf.o_free_cnt, 2);
    checkOutput("t2_freed_ready", rsIf.o_ready_vec, 0);

    // src2 waits for tag 9, wrong-tag broadcast ignored, grant to non-ready entry
    applyStimulus(16'h0003, 1'b1, 6'd0, 32'd1, 1'b0, 6'd9, 32'd0);
    tick();
    checkOutput("t3_not_ready", rsIf.o_ready_vec, 0);
    checkOutput("t3_free_cnt", rsIf.o_free_cnt, 1);
    rsIf.i_cdb0_vld  = 1'b1;
    rsIf.i_cdb0_tag  = 6'd8;
    rsIf.i_cdb0_data = 32'hDEAD;
    grant(1'b0);
    checkOutput("t3_grant_nonready", rsIf.o_issue_vld, 0);
    tick();
    checkOutput("t3_entry_kept", rsIf.o_free_cnt, 1);
    checkOutput("t3_wrong_tag", rsIf.o_ready_vec, 0);
    rsIf.i_cdb1_vld  = 1'b1;
    rsIf.i_cdb1_tag  = 6'd9;
    rsIf.i_cdb1_data = 32'hAB;
    #1;
    checkOutput("t3_wake_same_cycle", rsIf.o_ready_vec, 0);
    tick();
    checkOutput("t3_woken", rsIf.o_ready_vec, 2'b01);
    grant(1'b0);
    checkOutput("t3_issue_vld", rsIf.o_issue_vld, 1);
    checkOutput("t3_issue_src2", rsIf.o_issue_src2, 32'hAB);
    checkOutput("t3_issue_src1", rsIf.o_issue_src1, 1);
    tick();

    // Dispatch/CDB same-cycle bypass
    applyStimulus(16'h0004, 1'b0, 6'd3, 32'd0, 1'b1, 6'd0, 32'h22);
    rsIf.i_cdb0_vld  = 1'b1;
    rsIf.i_cdb0_tag  = 6'd3;
    rsIf.i_cdb0_data = 32'h11;
    tick();
    checkOutput("t4_bypass_ready", rsIf.o_ready_vec, 2'b01);
    grant(1'b0);
    checkOutput("t4_issue_src1", rsIf.o_issue_src1, 32'h11);
    checkOutput("t4_issue_src2", rsIf.o_issue_src2, 32'h22);
    tick();

    // Both CDBs waking different sources of one entry
    applyStimulus(16'h0007, 1'b0, 6'd4, 32'd0, 1'b0, 6'd5, 32'd0);
    tick();
    rsIf.i_cdb0_vld  = 1'b1;
    rsIf.i_cdb0_tag  = 6'd5;
    rsIf.i_cdb0_data = 32'h55;
    rsIf.i_cdb1_vld  = 1'b1;
    rsIf.i_cdb1_tag  = 6'd4;
    rsIf.i_cdb1_data = 32'h44;
    tick();
    checkOutput("t7_dual_wake", rsIf.o_ready_vec, 2'b01);
    grant(1'b0);
    checkOutput("t7_src1", rsIf.o_issue_src1, 32'h44);
    checkOutput("t7_src2", rsIf.o_issue_src2, 32'h55);
    tick();

    // Fill, then issue+dispatch while full drops the dispatch
    applyStimulus(16'h000A, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    tick();
    applyStimulus(16'h000B, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
    tick();
    checkOutput("t5_full", rsIf.o_full, 1);
    checkOutput("t5_free_zero", rsIf.o_free_cnt, 0);
    checkOutput("t5_ready_both", rsIf.o_ready_vec, 2'b11);
    applyStimulus(16'h000C, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    grant(1'b0);
    checkOutput("t5_issue_a", rsIf.o_issue_payload, 16'h000A);
    tick();
    checkOutput("t5_dropped_full", rsIf.o_full, 0);
    checkOutput("t5_dropped_cnt", rsIf.o_free_cnt, 1);
    checkOutput("t5_dropped_ready", rsIf.o_ready_vec, 2'b10);
    applyStimulus(16'h000C, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    tick();
    checkOutput("t5_refill_ready", rsIf.o_ready_vec, 2'b11);
    grant(1'b0);
    checkOutput("t5_entry0_payload", rsIf.o_issue_payload, 16'h000C);
    checkOutput("t5_entry0_src1", rsIf.o_issue_src1, 5);
    tick();
    grant(1'b1);
    checkOutput("t5_entry1_payload", rsIf.o_issue_payload, 16'h000B);
    checkOutput("t5_entry1_src2", rsIf.o_issue_src2, 4);
    tick();
    checkOutput("t5_drained", rsIf.o_free_cnt, 2);

    // Reset mid-operation drops entries and a pending wakeup
    applyStimulus(16'h000D, 1'b0, 6'd6, 32'd0, 1'b1, 6'd0, 32'd1);
    tick();
    reset = 1'b1;
    rsIf.i_cdb0_vld  = 1'b1;
    rsIf.i_cdb0_tag  = 6'd6;
    rsIf.i_cdb0_data = 32'h66;
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_free", rsIf.o_free_cnt, 2);
    checkOutput("rst_mid_ready", rsIf.o_ready_vec, 0);

    // Flush with a same-cycle dispatch
    applyStimulus(16'h00E0, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2);
    tick();
    applyStimulus(16'h00E1, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 32'd4);
    tick();
    applyStimulus(16'h00E2, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 32'd6);
    rsIf.i_flush = 1'b1;
`ifdef RS_FLUSH_EN
    grant(1'b0);
    checkOutput("flush_issue_blocked", rsIf.o_issue_vld, 0);
    tick();
    checkOutput("flush_free_cnt", rsIf.o_free_cnt, 2);
    checkOutput("flush_ready_vec", rsIf.o_ready_vec, 0);
`else
    #1;
    tick();
    checkOutput("noflush_free_cnt", rsIf.o_free_cnt, 0);
    checkOutput("noflush_ready_vec", rsIf.o_ready_vec, 2'b11);
    rsIf.i_flush = 1'b1;
    grant(1'b1);
    checkOutput("noflush_issue_vld", rsIf.o_issue_vld, 1);
    checkOutput("noflush_payload", rsIf.o_issue_payload, 16'h00E1);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
